// File: rtl/fir_seq_pkg.sv
// fir_seq_pkg
//   Shared types and constants for the FIR byte-serial sequencer.
//   - seq_state_t      : sequencer FSM states
//   - BYTES_PER_SAMPLE : bytes per 32-bit sample/result
//   - BIDX_W           : width of the byte-index counters
package fir_seq_pkg;

    localparam int BYTES_PER_SAMPLE = 4;
    localparam int BIDX_W           = $clog2(BYTES_PER_SAMPLE);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        START  = 2'd1,
        WAIT   = 2'd2,
        UNLOAD = 2'd3
    } seq_state_t;

endpackage

// File: rtl/fir_seq_watchdog.sv
// fir_seq_watchdog
//   Cycle counter guarding the wait for the core's done pulse.
//   Ports:
//     clk, rst_n : clock, async active-low reset
//     clr        : synchronous clear to zero (has priority over en)
//     en         : count one per cycle while high
//     expired    : high while enabled and the count sits at MAX_WAIT-1,
//                  i.e. during the MAX_WAIT-th enabled cycle after a clear
module fir_seq_watchdog #(
    parameter int MAX_WAIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] cnt;
    logic             at_limit;

    assign at_limit = (cnt == LIMIT);
    assign expired  = en && at_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !at_limit) begin
            // Holds at the limit; the sequencer leaves WAIT on expiry anyway.
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fir_io_sequencer.sv
// fir_io_sequencer
//   Byte-serial front end and start/done sequencer for the FIR core.
//   Collects four little-endian bytes into a sample, pulses core_start,
//   waits for core_done under a watchdog, then returns the result low
//   byte first.
//   Ports:
//     clk, rst_n                    : clock, async active-low reset
//     in_byte/in_valid/in_ready     : input byte stream (accepted in LOAD)
//     out_byte/out_valid/out_ready  : result byte stream (driven in UNLOAD)
//     core_x/core_start             : sample and one-cycle start to core
//     core_y/core_done              : core result and completion pulse
//     busy                          : high whenever not in LOAD
//     timeout_err/err_clr           : sticky watchdog flag and its clear
module fir_io_sequencer
    import fir_seq_pkg::*;
#(
    parameter int SAMPLE_W = 32,
    parameter int BYTE_W   = 8,
    parameter int MAX_WAIT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BYTE_W-1:0]   in_byte,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [BYTE_W-1:0]   out_byte,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] core_x,
    output logic                core_start,
    input  logic [SAMPLE_W-1:0] core_y,
    input  logic                core_done,
    output logic                busy,
    output logic                timeout_err,
    input  logic                err_clr
);

    localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BYTES_PER_SAMPLE - 1);

    seq_state_t          state, state_nxt;
    logic [BIDX_W-1:0]   in_cnt;
    logic [BIDX_W-1:0]   out_cnt;
    logic [SAMPLE_W-1:0] sample;
    logic [SAMPLE_W-1:0] result;

    logic in_acc;
    logic out_acc;
    logic wd_clr;
    logic wd_en;
    logic wd_expired;
    logic got_done;
    logic timed_out;

    // ------------------------------------------------------------------
    // Watchdog: cleared in START so the first WAIT cycle sees zero.
    // ------------------------------------------------------------------
    assign wd_clr = (state == START);
    assign wd_en  = (state == WAIT);

    fir_seq_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    // ------------------------------------------------------------------
    // Handshake and event decode (all from registered state)
    // ------------------------------------------------------------------
    assign in_ready   = (state == LOAD);
    assign out_valid  = (state == UNLOAD);
    assign core_start = (state == START);
    assign busy       = (state != LOAD);
    assign core_x     = sample;

    assign in_acc    = in_ready && in_valid;
    assign out_acc   = out_valid && out_ready;
    assign got_done  = (state == WAIT) && core_done;
    // A done arriving on the final watchdog cycle takes precedence.
    assign timed_out = wd_expired && !core_done;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (in_acc && in_cnt == LAST_IDX) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT: begin
                if (got_done)       state_nxt = UNLOAD;
                else if (timed_out) state_nxt = LOAD;
            end
            UNLOAD:  if (out_acc && out_cnt == LAST_IDX) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // ------------------------------------------------------------------
    // Input assembly. Counters wrap naturally after the last byte, which
    // leaves them at zero for the next sample. sample is only written in
    // LOAD, so core_x stays put through START and WAIT.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt <= '0;
            sample <= '0;
        end else if (in_acc) begin
            in_cnt <= in_cnt + 1'b1;
            for (int k = 0; k < BYTES_PER_SAMPLE; k++) begin
                if (in_cnt == BIDX_W'(k))
                    sample[k*BYTE_W +: BYTE_W] <= in_byte;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result capture and byte-serial unload
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
        end else if (got_done) begin
            result <= core_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt <= '0;
        end else if (out_acc) begin
            out_cnt <= out_cnt + 1'b1;
        end
    end

    // out_byte is forced to zero outside UNLOAD so stale results never
    // appear on the pins.
    always_comb begin
        out_byte = '0;
        if (state == UNLOAD) begin
            for (int j = 0; j < BYTES_PER_SAMPLE; j++) begin
                if (out_cnt == BIDX_W'(j))
                    out_byte = result[j*BYTE_W +: BYTE_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky timeout flag: a new expiry beats a simultaneous clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (timed_out) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_io_sequencer.sv
module tb_fir_io_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] core_x;
    logic        core_start;
    logic [31:0] core_y;
    logic        core_done;
    logic        busy;
    logic        timeout_err;
    logic        err_clr;

    int checks = 0;
    int errors = 0;
    int starts = 0;
    int s0;

    fir_io_sequencer #(
        .SAMPLE_W (32),
        .BYTE_W   (8),
        .MAX_WAIT (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_byte    (out_byte),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .core_x      (core_x),
        .core_start  (core_start),
        .core_y      (core_y),
        .core_done   (core_done),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    // Counts every cycle in which core_start is high.
    always @(posedge clk) if (core_start === 1'b1) starts <= starts + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives four bytes back-to-back, little-endian; ends with state START.
    task automatic load_sample(input logic [31:0] w);
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_byte = w[k*8 +: 8];
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_byte = '0; in_valid = 1'b0; out_ready = 1'b0;
        core_y = '0; core_done = 1'b0; err_clr = 1'b0;
        tick(); tick();
        chk("rst_in_ready",    32'(in_ready),    32'd1);
        chk("rst_out_valid",   32'(out_valid),   32'd0);
        chk("rst_out_byte",    32'(out_byte),    32'd0);
        chk("rst_core_x",      core_x,           32'd0);
        chk("rst_core_start",  32'(core_start),  32'd0);
        chk("rst_busy",        32'(busy),        32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // ---- basic sample, constant in_valid ----
        s0 = starts;
        load_sample(32'h12345678);
        chk("t1_core_start", 32'(core_start), 32'd1);
        chk("t1_core_x",     core_x,          32'h12345678);
        chk("t1_in_ready",   32'(in_ready),   32'd0);
        chk("t1_busy",       32'(busy),       32'd1);
        tick();
        chk("t1_start_drop", 32'(core_start), 32'd0);
        chk("t1_one_start",  32'(starts - s0), 32'd1);
        repeat (3) tick();
        core_done = 1'b1; core_y = 32'hDEADBEEF; out_ready = 1'b1;
        tick();
        core_done = 1'b0; core_y = '0;
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_in_ready_u", 32'(in_ready), 32'd0);
        chk("t1_b0", 32'(out_byte), 32'hEF); tick();
        chk("t1_b1", 32'(out_byte), 32'hBE); tick();
        chk("t1_b2", 32'(out_byte), 32'hAD); tick();
        chk("t1_b3", 32'(out_byte), 32'hDE); tick();
        chk("t1_end_valid", 32'(out_valid), 32'd0);
        chk("t1_end_ready", 32'(in_ready),  32'd1);
        chk("t1_end_busy",  32'(busy),      32'd0);

        // core_done while in LOAD is ignored
        core_done = 1'b1; core_y = 32'h55555555;
        tick();
        core_done = 1'b0;
        chk("stray_done_valid", 32'(out_valid), 32'd0);
        chk("stray_done_busy",  32'(busy),      32'd0);

        // ---- gapped input, ignored bytes, output backpressure ----
        out_ready = 1'b0;
        in_valid = 1'b1; in_byte = 8'h01; tick();
        in_valid = 1'b0; in_byte = 8'h99; tick();
        in_valid = 1'b1; in_byte = 8'h02; tick();
        in_byte = 8'h03; tick();
        in_byte = 8'h04; tick();
        chk("t2_core_x", core_x, 32'h04030201);
        in_byte = 8'hFF;                 // in_valid stays high, must be ignored
        tick();
        chk("t2_wait_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("t2_core_x_hold", core_x, 32'h04030201);
        core_done = 1'b1; core_y = 32'hA1B2C3D4;
        tick();
        core_done = 1'b0; in_valid = 1'b0;
        chk("t2_c1", 32'(out_byte), 32'hD4); out_ready = 1'b1; tick();
        chk("t2_c2", 32'(out_byte), 32'hC3); out_ready = 1'b0; tick();
        chk("t2_c3", 32'(out_byte), 32'hC3); out_ready = 1'b0; tick();
        chk("t2_c4", 32'(out_byte), 32'hC3); out_ready = 1'b1; tick();
        chk("t2_c5", 32'(out_byte), 32'hB2); tick();
        chk("t2_c6", 32'(out_byte), 32'hA1); tick();
        chk("t2_end_ready", 32'(in_ready), 32'd1);
        chk("t2_no_ff_write", core_x, 32'h04030201);

        // ---- watchdog expiry ----
        s0 = starts;
        load_sample(32'hCAFE0001);
        tick();                           // first WAIT cycle
        repeat (63) tick();
        chk("t3_pre_err",  32'(timeout_err), 32'd0);
        chk("t3_pre_busy", 32'(busy),        32'd1);
        tick();
        chk("t3_err",       32'(timeout_err), 32'd1);
        chk("t3_in_ready",  32'(in_ready),    32'd1);
        chk("t3_busy",      32'(busy),        32'd0);
        chk("t3_out_valid", 32'(out_valid),   32'd0);
        chk("t3_starts",    32'(starts - s0), 32'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t3_cleared", 32'(timeout_err), 32'd0);

        // expiry and clear in the same cycle: set wins
        load_sample(32'hCAFE0002);
        tick();
        repeat (63) tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t3_set_wins", 32'(timeout_err), 32'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t3_clear2", 32'(timeout_err), 32'd0);

        // ---- done on the final watchdog cycle ----
        load_sample(32'hCAFE0003);
        tick();
        repeat (63) tick();
        core_done = 1'b1; core_y = 32'h0BADF00D; out_ready = 1'b1;
        tick();
        core_done = 1'b0;
        chk("t4_valid", 32'(out_valid),   32'd1);
        chk("t4_noerr", 32'(timeout_err), 32'd0);
        chk("t4_b0", 32'(out_byte), 32'h0D); tick();
        chk("t4_b1", 32'(out_byte), 32'hF0); tick();
        chk("t4_b2", 32'(out_byte), 32'hAD); tick();
        chk("t4_b3", 32'(out_byte), 32'h0B); tick();
        chk("t4_end_ready", 32'(in_ready), 32'd1);

        // ---- reset in the middle of a load ----
        in_valid = 1'b1; in_byte = 8'hAA; tick();
        in_byte = 8'hBB; tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("t5_rst_core_x", core_x, 32'd0);
        chk("t5_rst_ready",  32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        s0 = starts;
        in_valid = 1'b1;
        in_byte = 8'h01; tick();
        in_byte = 8'h00; tick();
        in_byte = 8'h00; tick();
        in_valid = 1'b0; tick();
        chk("t5_no_stray_start", 32'(starts - s0), 32'd0);
        chk("t5_still_load",     32'(in_ready),    32'd1);
        in_valid = 1'b1; in_byte = 8'h00; tick();
        in_valid = 1'b0;
        chk("t5_core_start", 32'(core_start), 32'd1);
        chk("t5_core_x",     core_x,          32'h00000001);
        tick();
        chk("t5_one_start",  32'(starts - s0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_io_sequencer.md
# fir_io_sequencer

Byte-serial front end and sequencer for the 32-bit FIR core on the 8-bit Tiny Tapeout pins. Assembles four input bytes into one sample, issues a single start to the core, waits for its done pulse under a watchdog, then streams the 32-bit result back out one byte at a time. Sits between the top-level pin wrapper and the FIR core; owns all start/done sequencing for the core.

## Interface
- SAMPLE_W, 32, sample and result width; must be 4 × BYTE_W
- BYTE_W, 8, pin-side byte width
- MAX_WAIT, 64, watchdog limit in cycles for core_done after core_start; must be ≥ 2
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_byte  in  BYTE_W  input byte
- in_valid  in  1  in_byte valid
- in_ready  out  1  block accepts in_byte this cycle
- out_byte  out  BYTE_W  result byte
- out_valid  out  1  out_byte valid
- out_ready  in  1  consumer accepts out_byte
- core_x  out  SAMPLE_W  sample presented to core
- core_start  out  1  one-cycle start pulse to core
- core_y  in  SAMPLE_W  core result, valid with core_done
- core_done  in  1  one-cycle completion pulse from core
- busy  out  1  high in START, WAIT, UNLOAD
- timeout_err  out  1  sticky watchdog error flag
- err_clr  in  1  clears timeout_err

## Operation
- States: LOAD, START, WAIT, UNLOAD. Reset state LOAD.
- LOAD: in_ready=1. Byte accepted on in_valid&in_ready into sample[8k+7:8k], k = byte count 0..3. Little-endian: first byte is bits [7:0]. On acceptance with k=3 → START, k clears.
- START: core_start=1 for exactly one cycle; core_x = assembled sample. Next state WAIT, watchdog cleared.
- WAIT: watchdog increments each cycle. core_done=1 → capture core_y into result register, → UNLOAD. Watchdog reaches MAX_WAIT−1 with core_done=0 → set timeout_err, discard, → LOAD. Done and final watchdog cycle together: done wins, no error.
- UNLOAD: out_valid=1, out_byte = result[8j+7:8j], j = 0..3, low byte first. j advances on out_valid&out_ready; after j=3 transfer → LOAD.
- core_x held stable from START until leaving WAIT; core_done outside WAIT ignored.
- in_valid outside LOAD ignored (no acceptance, in_ready=0).
- timeout_err: set in WAIT on expiry, cleared by err_clr; set and clear same cycle → set wins. Does not block operation.
- Reset at any point: state LOAD, counts zero, partial sample and pending result discarded, no core_start emitted.

## Timing
- Reset values: in_ready=1, out_valid=0, out_byte=0, core_x=0, core_start=0, busy=0, timeout_err=0.
- All outputs decoded from registers; no combinational path from input to output except none (in_ready, out_valid state-decoded).
- 4th input byte accepted at edge N → core_start high cycle N+1 → WAIT from N+2.
- core_done at cycle M → out_valid high cycle M+1.
- out_byte stable while out_valid & !out_ready.
- Minimum sample period with zero backpressure: 4 (LOAD) + 1 (START) + core latency + 4 (UNLOAD) cycles.
- Watchdog expiry: with no done, timeout_err rises MAX_WAIT cycles after entering WAIT; in_ready=1 the cycle after.

## Structure
- Package fir_seq_pkg: state enum (LOAD, START, WAIT, UNLOAD), BYTES_PER_SAMPLE=4, byte-index width constant.
- Sub-module fir_seq_watchdog: clear/enable counter with MAX_WAIT parameter, expiry output; instantiated once.
- Top holds FSM, sample/result registers, byte counters.

## Test plan
- Bytes 0x78,0x56,0x34,0x12 with in_valid constant → core_x=0x12345678, single core_start one cycle after 4th byte.
- Core model returns core_y=0xDEADBEEF 5 cycles after start, out_ready=1 → out_byte 0xEF,0xBE,0xAD,0xDE on 4 consecutive cycles, then in_ready=1.
- out_ready toggled 1-0-0-1 during UNLOAD → out_byte held on stalls, no byte skipped or repeated.
- Core never asserts done, MAX_WAIT=64 → timeout_err=1 64 cycles into WAIT, state LOAD; err_clr pulse → 0; err_clr same cycle as expiry → stays 1.
- core_done on final watchdog cycle → result unloaded, timeout_err=0.
- rst_n low after 2 bytes loaded, then full new sample 0x00000001 → core_x=0x00000001, no stray core_start.
